// File: rtl/redundant_to_binary.sv
// Carry-resolution stage: walks a captured redundant-form result one coefficient
// per clock and produces a canonical binary value plus a final carry (0..2).
module redundant_to_binary #(
    parameter int MOD_LEN               = 1024,
    parameter int WORD_LEN              = 16,
    parameter int REDUNDANT_ELEMENTS    = 2,
    parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
    parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
    parameter int COEFF_BITS            = 17,
    parameter int IN_BITS               = NUM_ELEMENTS * WORD_LEN * 2,
    parameter int OUT_BITS              = NUM_ELEMENTS * WORD_LEN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_coeffs,
    output logic [OUT_BITS-1:0] out_data,
    output logic [1:0]          out_carry,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                overrun
);

    localparam int SLOT_W = 2 * WORD_LEN;
    localparam int IDX_W  = $clog2(NUM_ELEMENTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                                   state_q;
    logic [IDX_W-1:0]                         idx_q;
    logic [1:0]                               carry_q;
    logic [NUM_ELEMENTS-1:0][COEFF_BITS-1:0]  coeff_q;
    logic [OUT_BITS-1:0]                      out_data_q;
    logic [1:0]                               out_carry_q;
    logic                                     out_valid_q;
    logic                                     busy_q;
    logic                                     overrun_q;

    logic [NUM_ELEMENTS-1:0][COEFF_BITS-1:0]  cap_d;
    logic [COEFF_BITS:0]                      sum_d;
    logic [1:0]                               carry_d;
    logic [NUM_ELEMENTS-1:0]                  unused_slot_hi;

    // Slot bits above COEFF_BITS are junk from the squarer and are discarded.
    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_slot
        assign cap_d[j]          = in_coeffs[j*SLOT_W +: COEFF_BITS];
        assign unused_slot_hi[j] = ^in_coeffs[j*SLOT_W+COEFF_BITS +: SLOT_W-COEFF_BITS];
    end

    always_comb begin
        sum_d   = {1'b0, coeff_q[idx_q]} + {{(COEFF_BITS-1){1'b0}}, carry_q};
        carry_d = sum_d[WORD_LEN +: 2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= '0;
            coeff_q     <= '0;
            out_data_q  <= '0;
            out_carry_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        coeff_q <= cap_d;
                        carry_q <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid) overrun_q <= 1'b1;
                    out_data_q[idx_q*WORD_LEN +: WORD_LEN] <= sum_d[WORD_LEN-1:0];
                    carry_q <= carry_d;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        out_carry_q <= carry_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        idx_q       <= '0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        // A capture coincident with the handshake is not an overrun.
                        if (in_valid) begin
                            coeff_q <= cap_d;
                            carry_q <= '0;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (in_valid) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_redundant_to_binary.sv
// Self-checking bench for redundant_to_binary: fixed vectors, random vectors
// against an arithmetic model, stall/overrun and mid-run reset sequences.
module tb_redundant_to_binary;

    localparam int WL = 16;
    localparam int NE = 66;
    localparam int CB = 17;
    localparam int IB = NE * WL * 2;
    localparam int OB = NE * WL;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [IB-1:0] in_coeffs;
    logic [OB-1:0] out_data;
    logic [1:0]    out_carry;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          overrun;

    int n_checks = 0;
    int n_fail   = 0;

    redundant_to_binary dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_coeffs (in_coeffs),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [IB-1:0] coeffs;
        logic [OB-1:0] exp_data;
        logic [1:0]    exp_carry;
    } vec_t;

    vec_t tbl[4];

    // Exact value: sum of each coefficient's low CB bits weighted by 2^(WL*j).
    function automatic logic [OB+1:0] model(input logic [IB-1:0] c);
        logic [OB+1:0] acc;
        logic [OB+1:0] term;
        acc = '0;
        for (int j = 0; j < NE; j++) begin
            term = (OB+2)'(c[j*2*WL +: CB]);
            acc  = acc + (term << (WL * j));
        end
        return acc;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [OB-1:0] act, input logic [OB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int j = 0; j < NE; j++) begin
                if (act[j*WL +: WL] !== exp[j*WL +: WL]) begin
                    $display("FAIL %s: digit %0d got %h expected %h", nm, j,
                             act[j*WL +: WL], exp[j*WL +: WL]);
                    break;
                end
            end
        end
    endtask

    // Pulse in_valid for one edge (E0); returns at the negedge after E0.
    task automatic issue(input logic [IB-1:0] c);
        @(negedge clk);
        in_coeffs = c;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Starts at the negedge after E0; waits for out_valid and checks the result.
    task automatic wait_done(input string nm, input logic [OB-1:0] ed, input logic [1:0] ec);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(NE));
        chk_data({nm, " data"}, out_data, ed);
        chk({nm, " carry"}, 64'(out_carry), 64'(ec));
        if (out_ready) begin
            @(negedge clk);
            chk({nm, " valid one cycle"}, 64'(out_valid), 64'd0);
        end
    endtask

    task automatic run_conv(input string nm, input logic [IB-1:0] c,
                            input logic [OB-1:0] ed, input logic [1:0] ec);
        issue(c);
        chk({nm, " busy"}, 64'(busy), 64'd1);
        wait_done(nm, ed, ec);
    endtask

    initial begin
        logic [IB-1:0] c;
        logic [IB-1:0] c2;
        logic [OB+1:0] m;
        logic [OB-1:0] held;

        // Fixed vectors with hand-derived expectations.
        tbl[0].name = "all_one";  tbl[0].coeffs = '0; tbl[0].exp_data = '0; tbl[0].exp_carry = 2'd0;
        tbl[1].name = "c0_max";   tbl[1].coeffs = '0; tbl[1].exp_data = '0; tbl[1].exp_carry = 2'd0;
        tbl[2].name = "all_max";  tbl[2].coeffs = '0; tbl[2].exp_data = '0; tbl[2].exp_carry = 2'd2;
        tbl[3].name = "junk_hi";  tbl[3].coeffs = '0; tbl[3].exp_data = '0; tbl[3].exp_carry = 2'd0;
        for (int j = 0; j < NE; j++) begin
            tbl[0].coeffs[j*2*WL +: 2*WL] = 32'h0000_0001;
            tbl[0].exp_data[j*WL +: WL]   = 16'h0001;
            tbl[2].coeffs[j*2*WL +: 2*WL] = 32'h0001_FFFF;
            tbl[2].exp_data[j*WL +: WL]   = (j == 0) ? 16'hFFFF : (j == 1) ? 16'h0000 : 16'h0001;
            tbl[3].coeffs[j*2*WL +: 2*WL] = 32'hABC0_0000 | 32'(j);
            tbl[3].exp_data[j*WL +: WL]   = 16'(j);
        end
        tbl[1].coeffs[2*WL-1:0] = 32'h0001_FFFF;
        tbl[1].exp_data[2*WL-1:0] = 32'h0001_FFFF;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_coeffs = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset overrun", 64'(overrun), 64'd0);
        chk("reset carry", 64'(out_carry), 64'd0);
        chk_data("reset data", out_data, '0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++)
            run_conv(tbl[i].name, tbl[i].coeffs, tbl[i].exp_data, tbl[i].exp_carry);

        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < NE; j++) c[j*2*WL +: 2*WL] = $urandom();
            m = model(c);
            run_conv($sformatf("rand%0d", i), c, m[OB-1:0], m[OB +: 2]);
        end
        chk("no overrun in normal flow", 64'(overrun), 64'd0);

        // Stall with out_ready low; a dropped pulse sets overrun.
        for (int j = 0; j < NE; j++) c[j*2*WL +: 2*WL] = $urandom();
        for (int j = 0; j < NE; j++) c2[j*2*WL +: 2*WL] = $urandom();
        out_ready = 1'b0;
        m = model(c);
        run_conv("stall", c, m[OB-1:0], m[OB +: 2]);
        held = out_data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 3) begin
                in_coeffs = c2;
                in_valid  = 1'b1;
            end
            if (k == 4) in_valid = 1'b0;
            chk($sformatf("stall valid %0d", k), 64'(out_valid), 64'd1);
            chk_data($sformatf("stall data %0d", k), out_data, held);
        end
        chk("overrun set", 64'(overrun), 64'd1);

        // Pulse coincident with the handshake is accepted.
        for (int j = 0; j < NE; j++) c[j*2*WL +: 2*WL] = $urandom();
        out_ready = 1'b1;
        in_coeffs = c;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        chk("handshake busy", 64'(busy), 64'd1);
        chk("handshake valid drop", 64'(out_valid), 64'd0);
        m = model(c);
        wait_done("coincident", m[OB-1:0], m[OB +: 2]);

        // Reset while at idx 30 aborts the run and clears everything.
        issue(tbl[2].coeffs);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset overrun", 64'(overrun), 64'd0);
        chk("midreset carry", 64'(out_carry), 64'd0);
        chk_data("midreset data", out_data, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset no valid", 64'(out_valid), 64'd0);
        for (int j = 0; j < NE; j++) c[j*2*WL +: 2*WL] = $urandom();
        m = model(c);
        run_conv("after_reset", c, m[OB-1:0], m[OB +: 2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
